// File: rtl/issue_queue_pkg.sv
// Shared types for rename-to-issue dispatch: request lanes, per-queue demand
// counts and credit widths, plus the lane-counting helper.
package issue_queue_pkg;

  localparam int MACHINE_WIDTH = 2;
  localparam int WRITE_NUM     = MACHINE_WIDTH;
  localparam int ALU_NUM       = 2;
  localparam int ALU_REL_MAX   = ALU_NUM;

  localparam int ALU_QUEUE_LEN_DEF    = 32;
  localparam int MEM_QUEUE_LEN_DEF    = 32;
  localparam int BRANCH_QUEUE_LEN_DEF = 16;
  localparam int MULT_QUEUE_LEN_DEF   = 8;

  typedef enum logic [1:0] {
    ET_ALU    = 2'd0,
    ET_MEM    = 2'd1,
    ET_BRANCH = 2'd2,
    ET_MULT   = 2'd3
  } entry_type_t;

  typedef struct packed {
    logic        valid;
    entry_type_t entry_type;
    logic [5:0]  tag;
  } write_req_t;

  localparam int REQ_W     = $bits(write_req_t);
  localparam int NEED_W    = $clog2(WRITE_NUM + 1);
  localparam int ALU_REL_W = $clog2(ALU_REL_MAX + 1);

  typedef logic [NEED_W-1:0] need_cnt_t;

  typedef struct packed {
    need_cnt_t alu;
    need_cnt_t mem;
    need_cnt_t branch;
    need_cnt_t mult;
  } dispatch_need_t;

  typedef logic [$clog2(ALU_QUEUE_LEN_DEF+1)-1:0]    alu_credit_t;
  typedef logic [$clog2(MEM_QUEUE_LEN_DEF+1)-1:0]    mem_credit_t;
  typedef logic [$clog2(BRANCH_QUEUE_LEN_DEF+1)-1:0] branch_credit_t;
  typedef logic [$clog2(MULT_QUEUE_LEN_DEF+1)-1:0]   mult_credit_t;

  function automatic need_cnt_t count_type(input write_req_t [WRITE_NUM-1:0] reqs,
                                           input entry_type_t                 t);
    need_cnt_t n;
    n = '0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      if (reqs[i].valid && reqs[i].entry_type == t) n = n + need_cnt_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/issue_credit_counter.sv
// Free-slot counter for one issue queue: debited on dispatch, credited on
// issue, and restored to full depth on reset or flush.
module issue_credit_counter
  import issue_queue_pkg::*;
#(
  parameter int  LEN    = 8,
  parameter int  REL_W  = 1,
  parameter int  CON_W  = NEED_W,
  localparam int CW     = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [CON_W-1:0] consume,
  input  logic [REL_W-1:0] release_cnt,
  output logic [CW-1:0]    credit
);

  // One extra bit so an over-release or under-run shows up as a value above LEN.
  logic [CW:0] nxt;
  assign nxt = {1'b0, credit} + (CW+1)'(release_cnt) - (CW+1)'(consume);

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) credit <= CW'(LEN);
    else                credit <= nxt[CW-1:0];
  end

  credit_in_range: assert property (@(posedge clk) disable iff (reset || flush)
                                    nxt <= (CW+1)'(LEN))
    else $error("credit counter left range 0..LEN");

endmodule

// File: rtl/issue_dispatch_ctrl.sv
// Credit-based dispatch from rename into the ALU/MEM/BRANCH/MULT issue queues:
// all-or-nothing bundle acceptance and a single registered output stage.
module issue_dispatch_ctrl
  import issue_queue_pkg::*;
#(
  parameter int ALU_QUEUE_LEN    = ALU_QUEUE_LEN_DEF,
  parameter int MEM_QUEUE_LEN    = MEM_QUEUE_LEN_DEF,
  parameter int BRANCH_QUEUE_LEN = BRANCH_QUEUE_LEN_DEF,
  parameter int MULT_QUEUE_LEN   = MULT_QUEUE_LEN_DEF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic                                     in_valid,
  input  logic [WRITE_NUM-1:0][REQ_W-1:0]          in_req,
  output logic                                     in_ready,
  input  logic                                     rob_ok,
  output logic [WRITE_NUM-1:0][REQ_W-1:0]          out_req,
  input  logic [ALU_REL_W-1:0]                     alu_release,
  input  logic                                     mem_release,
  input  logic                                     branch_release,
  input  logic                                     mult_release,
  output logic [$clog2(ALU_QUEUE_LEN+1)-1:0]       alu_credit,
  output logic [$clog2(MEM_QUEUE_LEN+1)-1:0]       mem_credit,
  output logic [$clog2(BRANCH_QUEUE_LEN+1)-1:0]    branch_credit,
  output logic [$clog2(MULT_QUEUE_LEN+1)-1:0]      mult_credit,
  output logic [3:0]                               stall_type
);

  localparam int ALU_CW    = $clog2(ALU_QUEUE_LEN + 1);
  localparam int MEM_CW    = $clog2(MEM_QUEUE_LEN + 1);
  localparam int BRANCH_CW = $clog2(BRANCH_QUEUE_LEN + 1);
  localparam int MULT_CW   = $clog2(MULT_QUEUE_LEN + 1);

  write_req_t [WRITE_NUM-1:0] lanes;
  write_req_t [WRITE_NUM-1:0] out_q;
  dispatch_need_t             need;
  dispatch_need_t             consume;
  logic [3:0]                 short_q;

  assign lanes = in_req;

  assign need.alu    = count_type(lanes, ET_ALU);
  assign need.mem    = count_type(lanes, ET_MEM);
  assign need.branch = count_type(lanes, ET_BRANCH);
  assign need.mult   = count_type(lanes, ET_MULT);

  // Only registered credits are compared, keeping issue-side releases off this path.
  assign short_q = {ALU_CW'(need.alu)       > alu_credit,
                    MEM_CW'(need.mem)       > mem_credit,
                    BRANCH_CW'(need.branch) > branch_credit,
                    MULT_CW'(need.mult)     > mult_credit};

  assign stall_type = (in_valid && !flush) ? short_q : 4'b0000;
  assign in_ready   = in_valid && rob_ok && !flush && (short_q == 4'b0000);
  assign consume    = in_ready ? need : '0;

  issue_credit_counter #(.LEN(ALU_QUEUE_LEN), .REL_W(ALU_REL_W)) u_alu_credit (
    .clk(clk), .reset(reset), .flush(flush),
    .consume(consume.alu), .release_cnt(alu_release), .credit(alu_credit)
  );

  issue_credit_counter #(.LEN(MEM_QUEUE_LEN), .REL_W(1)) u_mem_credit (
    .clk(clk), .reset(reset), .flush(flush),
    .consume(consume.mem), .release_cnt(mem_release), .credit(mem_credit)
  );

  issue_credit_counter #(.LEN(BRANCH_QUEUE_LEN), .REL_W(1)) u_branch_credit (
    .clk(clk), .reset(reset), .flush(flush),
    .consume(consume.branch), .release_cnt(branch_release), .credit(branch_credit)
  );

  issue_credit_counter #(.LEN(MULT_QUEUE_LEN), .REL_W(1)) u_mult_credit (
    .clk(clk), .reset(reset), .flush(flush),
    .consume(consume.mult), .release_cnt(mult_release), .credit(mult_credit)
  );

  // NOTE: payload bits are reset with the valids only to keep the bus deterministic;
  // downstream qualifies every lane by valid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_q <= '0;
    end else if (in_ready) begin
      out_q <= lanes;
    end else begin
      for (int i = 0; i < WRITE_NUM; i++) out_q[i].valid <= 1'b0;
    end
  end

  assign out_req = out_q;

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Self-checking bench for issue_dispatch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a free-slot model of the four queues.
module tb_issue_dispatch_ctrl;
  import issue_queue_pkg::*;

  typedef write_req_t [WRITE_NUM-1:0] bundle_t;

  logic                 clk = 1'b0;
  logic                 reset, flush, in_valid, rob_ok, in_ready;
  bundle_t              in_lanes, out_lanes;
  logic [ALU_REL_W-1:0] alu_release;
  logic                 mem_release, branch_release, mult_release;
  logic [5:0]           alu_credit, mem_credit;
  logic [4:0]           branch_credit;
  logic [3:0]           mult_credit;
  logic [3:0]           stall_type;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      cred[4];
  int      qlen[4] = '{32, 32, 16, 8};
  bundle_t exp_out;

  issue_dispatch_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_req(in_lanes), .in_ready(in_ready), .rob_ok(rob_ok), .out_req(out_lanes),
    .alu_release(alu_release), .mem_release(mem_release),
    .branch_release(branch_release), .mult_release(mult_release),
    .alu_credit(alu_credit), .mem_credit(mem_credit),
    .branch_credit(branch_credit), .mult_credit(mult_credit),
    .stall_type(stall_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic write_req_t mk(input logic v, input entry_type_t t, input logic [5:0] tag);
    write_req_t r;
    r.valid = v; r.entry_type = t; r.tag = tag;
    return r;
  endfunction

  function automatic bundle_t bnd(input write_req_t a, input write_req_t b);
    bundle_t x;
    x[0] = a; x[1] = b;
    return x;
  endfunction

  function automatic int dut_cred(input int k);
    case (k)
      0:       return int'(alu_credit);
      1:       return int'(mem_credit);
      2:       return int'(branch_credit);
      default: return int'(mult_credit);
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_alu_credit"},    32'(dut_cred(0)), 32'(cred[0]));
    check({tag, "_mem_credit"},    32'(dut_cred(1)), 32'(cred[1]));
    check({tag, "_branch_credit"}, 32'(dut_cred(2)), 32'(cred[2]));
    check({tag, "_mult_credit"},   32'(dut_cred(3)), 32'(cred[3]));
    for (int i = 0; i < WRITE_NUM; i++) begin
      check({tag, "_out_valid"}, 32'(out_lanes[i].valid), 32'(exp_out[i].valid));
      if (exp_out[i].valid) check({tag, "_out_lane"}, 32'(out_lanes[i]), 32'(exp_out[i]));
    end
  endtask

  task automatic do_reset(input logic hold_valid);
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = hold_valid; rob_ok = 1'b1;
    in_lanes = bnd(mk(1, ET_MULT, 6'h3f), mk(1, ET_MULT, 6'h3e));
    alu_release = '0; mem_release = 0; branch_release = 0; mult_release = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) cred[k] = qlen[k];
    for (int i = 0; i < WRITE_NUM; i++) exp_out[i].valid = 1'b0;
    check_state("reset");
    in_valid = 1'b0;
    #1;
    check("reset_stall_type", 32'(stall_type), 32'd0);
  endtask

  // One clock: drive at negedge, check combinational outputs, then check registers after the edge.
  task automatic cycle(input logic v, input bundle_t lanes, input logic rob, input logic fl,
                       input int ar, input int mr, input int br, input int ur);
    int         need[4];
    int         rel[4];
    logic       exp_ready;
    logic [3:0] exp_stall;
    @(negedge clk);
    reset = 1'b0; in_valid = v; in_lanes = lanes; rob_ok = rob; flush = fl;
    alu_release = ALU_REL_W'(ar); mem_release = 1'(mr);
    branch_release = 1'(br); mult_release = 1'(ur);
    rel = '{ar, mr, br, ur};
    need = '{0, 0, 0, 0};
    for (int i = 0; i < WRITE_NUM; i++)
      if (lanes[i].valid) need[int'(lanes[i].entry_type)]++;
    exp_ready = v && rob && !fl;
    exp_stall = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (need[k] > cred[k]) begin
        exp_ready = 1'b0;
        exp_stall[3-k] = v && !fl;
      end
    end
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("stall_type", 32'(stall_type), 32'(exp_stall));
    @(posedge clk);
    if (fl) begin
      for (int k = 0; k < 4; k++) cred[k] = qlen[k];
      for (int i = 0; i < WRITE_NUM; i++) exp_out[i].valid = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) cred[k] = cred[k] - (exp_ready ? need[k] : 0) + rel[k];
      if (exp_ready) exp_out = lanes;
      else for (int i = 0; i < WRITE_NUM; i++) exp_out[i].valid = 1'b0;
    end
    #1;
    check_state("cycle");
  endtask

  initial begin
    bundle_t aa, mm, am, nn;
    reset = 1'b1; flush = 0; in_valid = 0; rob_ok = 0; in_lanes = '0;
    alu_release = '0; mem_release = 0; branch_release = 0; mult_release = 0;
    exp_out = '0;
    do_reset(1'b0);

    // Two ALU lanes accepted from reset.
    aa = bnd(mk(1, ET_ALU, 6'd1), mk(1, ET_ALU, 6'd2));
    cycle(1, aa, 1, 0, 0, 0, 0, 0);
    check("t1_alu_credit", 32'(alu_credit), 32'd30);
    check("t1_out_both_valid", 32'({out_lanes[1].valid, out_lanes[0].valid}), 32'b11);

    // Exhaust MULT credits, then a ninth MULT bundle stalls.
    mm = bnd(mk(1, ET_MULT, 6'd7), mk(0, ET_ALU, 6'd0));
    for (int i = 0; i < 8; i++) cycle(1, mm, 1, 0, 0, 0, 0, 0);
    check("t2_mult_zero", 32'(mult_credit), 32'd0);
    cycle(1, mm, 1, 0, 0, 0, 0, 0);
    check("t2_out_invalid", 32'({out_lanes[1].valid, out_lanes[0].valid}), 32'b00);

    // Mixed bundle blocked by MULT alone; a release lets it through a cycle later.
    am = bnd(mk(1, ET_ALU, 6'd9), mk(1, ET_MULT, 6'd10));
    cycle(1, am, 1, 0, 0, 0, 0, 0);
    check("t3_alu_unchanged", 32'(alu_credit), 32'd30);
    cycle(1, am, 1, 0, 0, 0, 0, 1);
    check("t3_mult_returned", 32'(mult_credit), 32'd1);
    cycle(1, am, 1, 0, 0, 0, 0, 0);
    check("t3_mult_back_zero", 32'(mult_credit), 32'd0);

    // Same-cycle release is not counted toward acceptance.
    for (int i = 0; i < 14; i++) cycle(1, aa, 1, 0, 0, 0, 0, 0);
    check("t4_alu_one", 32'(alu_credit), 32'd1);
    cycle(1, aa, 1, 0, 2, 0, 0, 0);
    check("t4_alu_three", 32'(alu_credit), 32'd3);
    cycle(1, aa, 1, 0, 0, 0, 0, 0);
    check("t4_alu_back_one", 32'(alu_credit), 32'd1);

    // Build credits 10/20/3/5 with a bundle pending, then flush.
    do_reset(1'b1);
    for (int i = 0; i < 11; i++) cycle(1, aa, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      cycle(1, bnd(mk(1, ET_MEM, 6'd3), mk(1, ET_MEM, 6'd4)), 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      cycle(1, bnd(mk(1, ET_BRANCH, 6'd5), mk(1, ET_BRANCH, 6'd6)), 1, 0, 0, 0, 0, 0);
    cycle(1, bnd(mk(1, ET_BRANCH, 6'd11), mk(1, ET_MULT, 6'd12)), 1, 0, 0, 0, 0, 0);
    cycle(1, mm, 1, 0, 0, 0, 0, 0);
    cycle(1, mm, 1, 0, 0, 0, 0, 0);
    check("t5_pre_credits",
          32'({alu_credit, mem_credit, branch_credit, mult_credit}),
          32'({6'd10, 6'd20, 5'd3, 4'd5}));
    cycle(1, aa, 1, 1, 1, 1, 1, 1);
    check("t5_post_credits",
          32'({alu_credit, mem_credit, branch_credit, mult_credit}),
          32'({6'd32, 6'd32, 5'd16, 4'd8}));

    // ROB back-pressure alone never shows as a credit stall.
    nn = bnd(mk(1, ET_MEM, 6'd20), mk(1, ET_BRANCH, 6'd21));
    cycle(1, nn, 0, 0, 0, 0, 0, 0);
    check("t6_no_stall", 32'(stall_type), 32'd0);
    cycle(1, nn, 1, 0, 0, 0, 0, 0);
    cycle(1, bnd(mk(0, ET_ALU, 6'd0), mk(0, ET_MULT, 6'd0)), 1, 0, 0, 0, 0, 0);

    // Randomized traffic with legal releases, occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      bundle_t rb;
      int amax, ar, mr, br, ur;
      if (n % 150 == 149) do_reset(1'b1);
      for (int i = 0; i < WRITE_NUM; i++)
        rb[i] = mk($urandom_range(0, 3) != 0, entry_type_t'($urandom_range(0, 3)),
                   6'($urandom_range(0, 63)));
      amax = qlen[0] - cred[0];
      if (amax > ALU_REL_MAX) amax = ALU_REL_MAX;
      ar = $urandom_range(0, amax);
      mr = (cred[1] < qlen[1] && $urandom_range(0, 2) == 0) ? 1 : 0;
      br = (cred[2] < qlen[2] && $urandom_range(0, 2) == 0) ? 1 : 0;
      ur = (cred[3] < qlen[3] && $urandom_range(0, 2) == 0) ? 1 : 0;
      cycle($urandom_range(0, 9) != 0, rb, $urandom_range(0, 4) != 0,
            $urandom_range(0, 29) == 0, ar, mr, br, ur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_dispatch_ctrl.md
Name: issue_dispatch_ctrl

Overview:
Credit-based dispatch controller between rename and the four issue queues (ALU, MEM, BRANCH, MULT).
- Accepts one rename bundle of WRITE_NUM write requests per cycle.
- Accepts a bundle atomically, and only when every target queue has enough free slots.
- Forwards accepted requests to the queues through one register stage.
- Keeps per-queue free-slot credits, which return on issue and are restored to full on pipeline flush.

Parameters:
WRITE_NUM, MACHINE_WIDTH (2), request lanes per bundle
ALU_QUEUE_LEN, 32, ALU queue depth
MEM_QUEUE_LEN, 32, MEM queue depth
BRANCH_QUEUE_LEN, 16, BRANCH queue depth
MULT_QUEUE_LEN, 8, MULT queue depth
ALU_REL_MAX, ALU_NUM (2), max ALU entries released per cycle

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush (mispredict/exception), synchronous
in_valid  in  1  rename bundle valid
in_req  in  WRITE_NUM x $bits(write_req_t)  bundle lanes; per-lane valid and entry_type
in_ready  out  1  bundle accepted this cycle (combinational)
rob_ok  in  1  ROB has room for the whole bundle
out_req  out  WRITE_NUM x $bits(write_req_t)  registered requests to the issue queues
alu_release  in  $clog2(ALU_REL_MAX+1)  ALU entries issued (freed) this cycle
mem_release  in  1  MEM entry freed
branch_release  in  1  BRANCH entry freed
mult_release  in  1  MULT entry freed
alu_credit, mem_credit, branch_credit, mult_credit  out  $clog2(LEN+1) each  current free slots
stall_type  out  4  one-hot per queue: that queue's credit is blocking the bundle (bit order ALU, MEM, BRANCH, MULT)

Behaviour:
- Reset (clk edge with reset=1): every credit = its LEN; all out_req lane valid = 0; stall_type = 0.
- Demand: need_X = count of lanes with valid=1 and entry_type==X. need_ALU ranges 0..WRITE_NUM.
- Accept: in_ready = in_valid & rob_ok & ~flush & (need_X <= credit_X for all four X).
- The accept test uses registered credits only; same-cycle releases are not counted (conservative, no comb path from issue).
- Atomicity: a bundle is accepted whole or not at all. No partial dispatch.
- Stall: stall_type[X] = in_valid & ~flush & (need_X > credit_X). It is independent of rob_ok.
- Credit update, each cycle: credit_X_next = credit_X - (in_ready ? need_X : 0) + release_X.
  - Width: LEN+1 states; arithmetic at the credit width plus 1.
  - Release and dispatch in the same cycle are both applied.
  - Simulation assertions: result never exceeds LEN and never goes below 0.
- Flush: on a clk edge with flush=1 and reset=0:
  - every credit = LEN, because the issue queues clear in the same cycle;
  - out_req valids clear;
  - releases in that cycle are ignored.
  - Flush has priority over in_valid; in_ready = 0 while flush=1.
- Output stage, latency 1:
  - if in_ready, out_req[i] <= in_req[i] with valid unchanged;
  - otherwise every out_req[i].valid <= 0.
  - Queues accept out_req unconditionally; credits guarantee space.
  - Lane order is preserved (program order = lane index).
- Reset has priority over flush. Reset during a stalled bundle drops the bundle; upstream must re-present it.
- Bundle with in_valid=1 and no valid lane: accepted (credits unchanged), out_req all invalid.
- No internal FSM beyond counters; state = 4 credit counters + WRITE_NUM output registers.

Decomposition:
- issue_queue_pkg additions:
  - typedef dispatch_need_t (4 counts);
  - typedef credit_t per queue width;
  - constant ALU_REL_MAX;
  - function count_type(write_req_t[WRITE_NUM], entry_type_t).
- Reuse write_req_t and entry_type_t unchanged.
- One natural sub-module: issue_credit_counter, parameterized by LEN and REL_W. It has inputs consume, release and flush, and outputs credit. It is instantiated four times.

Test Plan:
1. Reset, then in_valid with 2 ALU lanes, rob_ok=1 -> in_ready=1; next cycle out_req both valid; alu_credit 32->30.
2. Issue 8 single-MULT bundles with no release -> mult_credit=0. A 9th MULT bundle -> in_ready=0, stall_type=0001 (MULT bit set), out_req invalid.
3. mult_credit=0 with a bundle {ALU, MULT} -> whole bundle stalls, alu_credit unchanged. Then mult_release=1 -> next cycle in_ready=1 and mult_credit returns to 0.
4. alu_credit=1, bundle of 2 ALU, alu_release=2 same cycle -> stall (registered credit used), credit becomes 3. Next cycle accepted, credit becomes 1.
5. Flush asserted with an accepted bundle pending in out_req and credits at 10/20/3/5 -> next cycle all out_req invalid, credits 32/32/16/8; in_ready=0 during the flush cycle.
6. rob_ok=0 with ample credits -> in_ready=0, stall_type=0000; raise rob_ok -> accepted on that cycle.
